// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: glyph table,
// state encoding and default scan timing.
package seg_pkg;

  localparam int unsigned SHOW_CYCLES_DEF = 50000;
  localparam int unsigned GAP_CYCLES_DEF  = 500;

  localparam logic [0:0] S_GAP  = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side bundle for seg_scan_ctrl: value loading, blanking control and
// the multiplexed display drive.
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] value;
  logic        lz_blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  modport master (
    output load, value, lz_blank,
    input  seg, an, frame_done, pending
  );

  modport slave (
    input  load, value, lz_blank,
    output seg, an, frame_done, pending
  );
endinterface

// File: rtl/seg_scan_ctrl_hex_glyph.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_glyph
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = GLYPH[nib];
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit hex display scanner with blanking gaps between
// digits, frame-synchronous value commit and leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = SHOW_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input logic            CLOCK_50,
  input logic            RESET_N,
  seg_scan_ctrl_if.slave bus
);
  localparam int unsigned CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;
  logic             boundary;
  logic [3:0]       nib;
  logic [6:0]       glyph;
  logic             blank;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    case (state_q)
      S_GAP: begin
        if (GAP_CYCLES == 0 || cnt_q == GAP_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == SHOW_LAST) begin
          state_d  = (GAP_CYCLES == 0) ? S_SHOW : S_GAP;
          idx_d    = idx_q + 2'd1;
          cnt_d    = '0;
          boundary = (idx_q == 2'd3);
        end
      end
    endcase
  end

  // A load landing on the boundary cycle bypasses the pending register.
  always_comb begin
    disp_d     = disp_q;
    pend_val_d = bus.load ? bus.value : pend_val_q;
    pending_d  = pending_q;
    if (boundary) begin
      if (bus.load)      disp_d = bus.value;
      else if (pending_q) disp_d = pend_val_q;
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
  end

  assign nib = 4'(disp_q >> {idx_q, 2'b00});

  hex_glyph u_glyph (
    .nib (nib),
    .seg (glyph)
  );

  always_comb begin
    blank        = bus.lz_blank && (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0000);
    an_d         = AN_OFF;
    seg_d        = SEG_BLANK;
    frame_done_d = boundary;
    if (state_q == S_SHOW) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank ? SEG_BLANK : glyph;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_GAP;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= '0;
      pend_val_q   <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_val_q   <= pend_val_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SHOW_CYCLES, default 50000, clock cycles each digit is lit (1 ms at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 500, all-digits-off cycles between digits (anti-ghosting).
REQ-003 CLOCK_50  input  1  sole clock, rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  one-cycle strobe; capture value into the pending register.
REQ-006 value  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 lz_blank  input  1  enables leading-zero suppression.
REQ-008 seg  output  7  segment drive, active-low, bit 0 = segment a … bit 6 = segment g.
REQ-009 an  output  4  digit enable, active-low, an[k] lights digit k.
REQ-010 frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-011 pending  output  1  high while a loaded value awaits commit.

Function
REQ-012 States: S_GAP and S_SHOW; 2-bit digit index idx; cycle counter cnt sized for max(SHOW_CYCLES, GAP_CYCLES).
REQ-013 S_GAP lasts exactly GAP_CYCLES cycles, then moves to S_SHOW with cnt cleared.
REQ-014 If GAP_CYCLES = 0, S_GAP is skipped and S_SHOW follows S_SHOW directly.
REQ-015 S_SHOW lasts exactly SHOW_CYCLES cycles, then moves to S_GAP, idx increments, and cnt clears.
REQ-016 idx wraps 3 -> 0; frame length is 4*(SHOW_CYCLES+GAP_CYCLES) cycles.
REQ-017 seg and an are registered and change 1 cycle after a state or idx change.
REQ-018 In S_GAP: an = 4'hF and seg = 7'h7F.
REQ-019 In S_SHOW: an is all ones except an[idx] = 0, and seg is the hex glyph (0-9, A-F) of nibble idx of the display register.
REQ-020 Display register changes only at the frame boundary, i.e. the S_SHOW -> S_GAP transition with idx = 3; no tearing within a frame.
REQ-021 frame_done pulses for exactly the one cycle after the frame-boundary edge.
REQ-022 load = 1 writes value into the pending register and sets pending; a repeated load before commit overwrites it (last wins).
REQ-023 At the frame boundary with pending = 1, the display register takes the pending register and pending clears.
REQ-024 load asserted in the boundary cycle itself commits the incoming value directly; pending stays 0.
REQ-025 Leading-zero suppression: with lz_blank = 1, digit k (k = 3..1) shows seg = 7'h7F while an[k] = 0 if nibbles k..3 are all zero.
REQ-026 Digit 0 is never suppressed.
REQ-027 lz_blank is sampled every cycle (not frame-latched).

Reset
REQ-028 Reset state: state = S_GAP, idx = 0, cnt = 0, display and pending registers = 16'h0000, pending = 0.
REQ-029 Outputs during and immediately after reset: an = 4'hF, seg = 7'h7F, frame_done = 0.
REQ-030 Reset asserted mid-frame immediately forces all reset values, discarding any pending load.
REQ-031 First S_SHOW begins GAP_CYCLES cycles after RESET_N deassertion.

Structure
REQ-032 Shared package seg_pkg holds the 16-entry active-low glyph constants, the state encoding, and the default SHOW_CYCLES/GAP_CYCLES.
REQ-033 The glyph lookup is one combinational sub-module, hex_glyph (4-bit nibble in, 7-bit active-low seg out), instantiated once and time-shared across all four digits.

Verification (SHOW_CYCLES = 4, GAP_CYCLES = 1; frame = 20 cycles)
REQ-034 Reset release, no load -> an = 4'hF for 2 cycles, then an sequence E,F,D,F,B,F,7,F with each E/D/B/7 phase held 4 cycles; seg = 7'h40 ("0") on each shown digit; frame_done every 20 cycles.
REQ-035 load value = 16'h12AF mid-frame -> pending = 1 until the boundary; next frame shows digit0 F = 7'h0E, digit1 A = 7'h08, digit2 2 = 7'h24, digit3 1 = 7'h79; pending then clears.
REQ-036 Two loads 16'h1111 then 16'h2222 within one frame -> next frame displays 2222 only.
REQ-037 load 16'h0005 coincident with the boundary cycle -> 0005 is displayed from the immediately following frame; pending never asserts.
REQ-038 lz_blank = 1 with 16'h0005 -> digits 3..1 output seg = 7'h7F with their an active; digit 0 outputs 7'h12. With 16'h0000 -> only digit 0 lit, showing 7'h40.
REQ-039 RESET_N low during S_SHOW of digit 2 with pending = 1 -> an = 4'hF and seg = 7'h7F asynchronously; after release the display shows 0000 and pending = 0.
